elevator_controller: RTL
========================

# elevator_controller

Cabin scheduling stage fed by `buttons`. It consumes the latched request vectors `active_in_levels`, `active_out_up_levels` and `active_out_down_levels`. It runs a SCAN (collective) state machine that moves the cabin floor by floor and holds the door open on served floors. It returns one-cycle `inactivate_*` pulses and the `buttons_blocked` code to `buttons`, which closes the request/clear loop.

## Interface
- `BUTTONS_WIDTH`, 8: number of floors; one request bit per floor.
- `FLOOR_W`, `$clog2(BUTTONS_WIDTH)`: width of the floor index (derived, not overridden).
- `TRAVEL_TICKS`, 4: clock cycles per floor of travel (≥1).
- `DOOR_TICKS`, 8: clock cycles the door stays open (≥1).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `active_in_levels` in `BUTTONS_WIDTH`: cabin requests.
- `active_out_up_levels` in `BUTTONS_WIDTH`: hall up requests.
- `active_out_down_levels` in `BUTTONS_WIDTH`: hall down requests.
- `inactivate_in_levels` out `BUTTONS_WIDTH`: one-cycle clear pulses for cabin requests.
- `inactivate_out_up_levels` out `BUTTONS_WIDTH`: one-cycle clear pulses for hall up requests.
- `inactivate_out_down_levels` out `BUTTONS_WIDTH`: one-cycle clear pulses for hall down requests.
- `buttons_blocked` out 5: `current_floor+1` while the door is open, else 0.
- `current_floor` out `FLOOR_W`: cabin position.
- `direction` out 2: 00 none, 01 up, 10 down.
- `door_open` out 1: door-open indication.
- `moving` out 1: high in MOVE_UP and MOVE_DOWN.

## Operation
- Helper signals:
  - `req = in | up | down`.
  - `above` = any `req` bit > `current_floor`; `below` = any `req` bit < `current_floor`; `here` = `req[current_floor]`.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Reset state is IDLE.
- **IDLE**:
  - `here` → DOOR_OPEN.
  - else `above` → MOVE_UP with direction=01.
  - else `below` → MOVE_DOWN with direction=10.
  - else stay, with direction=00.
- **MOVE_UP / MOVE_DOWN**:
  - The travel counter loads `TRAVEL_TICKS-1` on entry and decrements each cycle.
  - At 0, `current_floor` steps ±1 and the stop test is evaluated at the new floor.
- **Stop test, going up at floor f**: `in[f] | up[f] | (down[f] & ~above_of_f)`. Going down mirrors this: `in[f] | down[f] | (up[f] & ~below_of_f)`.
  - Stop → DOOR_OPEN.
  - Otherwise continue in the same direction and reload the counter.
  - If there is no stop and no further request in the travel direction → IDLE.
- **Entry into DOOR_OPEN**: pulse `inactivate_in_levels[f]`. Also pulse the hall bit(s) being served:
  - direction up: the up bit, plus the down bit if the stop was taken on it.
  - direction down: mirror of the up case.
  - direction none: both hall bits at f.
  - Direction becomes the served direction: the opposite one when the turnaround down bit was taken.
- **In DOOR_OPEN**:
  - The door counter loads `DOOR_TICKS-1` and decrements.
  - A newly active request at f that matches the served set gets an inactivate pulse the cycle it is seen, and the door counter reloads (door reopen).
- **DOOR_OPEN exit** at counter 0:
  - direction up & `above` → MOVE_UP.
  - direction down & `below` → MOVE_DOWN.
  - else → IDLE with direction=00.
- Floor arithmetic never leaves 0..`BUTTONS_WIDTH-1`. Requests outside range cannot exist; requests that do not select a move are ignored.

## Timing
- Reset values: floor 0, IDLE, direction 00, `door_open` 0, `moving` 0, all inactivate outputs 0, `buttons_blocked` 0.
- All outputs are registered.
- Inactivate pulses are exactly 1 cycle, asserted in the first DOOR_OPEN cycle (or in a reopen cycle). Their effect on the `active_*` inputs is expected by the next cycle.
- IDLE→MOVE: 1 cycle after the request is seen.
- Each floor step: `TRAVEL_TICKS` cycles.
- Door open time: `DOOR_TICKS` cycles from last (re)entry.
- Request at the current floor while in IDLE: `door_open` rises 1 cycle later.
- A request arriving mid-travel at a floor still ahead is honoured if it is seen before the counter reaches 0 for that floor.
- Reset asserted mid-operation: immediately returns to the reset values; the counters clear.

## Configuration
- `ELEVATOR_ESTOP_EN`:
  - When defined, adds input `estop` (1 bit).
  - While `estop`=1: state, floor, counters and direction freeze; no inactivate pulses are issued; `moving`=0. If the FSM is in DOOR_OPEN, `door_open` is held at 1.
  - When `estop` is released, operation resumes from the frozen counter values.
  - Undefined: no port and no freeze logic.

## Test plan
- Reset, then `active_in_levels`=8'h08 → MOVE_UP next cycle; floor reaches 3 after 12 cycles; `door_open`=1 for 8 cycles; `inactivate_in_levels`=8'h08 for 1 cycle; `buttons_blocked`=4 during the door.
- Moving up from floor 0 with `up[2]` and `down[2]` set and nothing above 2 → stops at 2; both bits pulsed; direction becomes 10.
- Cabin at 5 in IDLE, `active_out_up_levels`=8'h20 → `door_open` next cycle; `inactivate_out_up_levels`=8'h20; no movement.
- During DOOR_OPEN at floor 1 (going up), `in[1]` re-asserted on door cycle 6 → pulse on `inactivate_in_levels[1]`; door stays open 8 more cycles.
- Requests at floors 6 and 1, cabin at 3 going up → serves 6 first, then reverses and serves 1; direction follows 01→10→00.
- Reset asserted mid-travel between floors 2 and 3 → all outputs return to reset values in the same cycle; with `ELEVATOR_ESTOP_EN`, `estop` for 10 cycles during travel delays arrival by exactly 10 cycles.

Source files
------------

// File: rtl/elevator_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// elevator_controller : SCAN (collective) cabin scheduler that closes the
// request/clear loop with the button latches. Optional macro ELEVATOR_ESTOP_EN.
// Revision 1.0
// -----------------------------------------------------------------------------
module elevator_controller #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int TRAVEL_TICKS  = 4,
  parameter int DOOR_TICKS    = 8,
  localparam int FLOOR_W      = $clog2(BUTTONS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                     estop,
`endif
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
  output logic [4:0]               buttons_blocked,
  output logic [FLOOR_W-1:0]       current_floor,
  output logic [1:0]               direction,
  output logic                     door_open,
  output logic                     moving
);

  localparam int TCW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DCW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TCW-1:0]     TRAVEL_LOAD = TCW'(TRAVEL_TICKS - 1);
  localparam logic [DCW-1:0]     DOOR_LOAD   = DCW'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(BUTTONS_WIDTH - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_MOVE_UP   = 2'd1;
  localparam logic [1:0] S_MOVE_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR_OPEN = 2'd3;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  logic [1:0]     state;
  logic [TCW-1:0] travel_cnt;
  logic [DCW-1:0] door_cnt;
  logic           served_up;
  logic           served_down;

  function automatic logic any_above(input logic [BUTTONS_WIDTH-1:0] v,
                                     input logic [FLOOR_W-1:0] fl);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (i > int'(fl) && v[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic any_below(input logic [BUTTONS_WIDTH-1:0] v,
                                     input logic [FLOOR_W-1:0] fl);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (i < int'(fl) && v[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [BUTTONS_WIDTH-1:0] onehot(input logic [FLOOR_W-1:0] fl);
    logic [BUTTONS_WIDTH-1:0] v;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      v[i] = (i == int'(fl));
    return v;
  endfunction

  logic [BUTTONS_WIDTH-1:0] req;
  logic [BUTTONS_WIDTH-1:0] hot_cur;
  logic [BUTTONS_WIDTH-1:0] hot_up;
  logic [BUTTONS_WIDTH-1:0] hot_dn;
  logic [FLOOR_W-1:0]       floor_up;
  logic [FLOOR_W-1:0]       floor_dn;
  logic                     above_cur;
  logic                     below_cur;
  logic                     here_cur;
  logic                     above_up;
  logic                     below_dn;
  logic                     turn_up;
  logic                     turn_dn;
  logic                     stop_up;
  logic                     stop_dn;
  logic [BUTTONS_WIDTH-1:0] reopen_in;
  logic [BUTTONS_WIDTH-1:0] reopen_up;
  logic [BUTTONS_WIDTH-1:0] reopen_dn;
  logic                     reopen;
  logic                     freeze;

  always_comb begin
    req       = active_in_levels | active_out_up_levels | active_out_down_levels;
    // Saturating neighbours keep floor arithmetic inside 0..TOP_FLOOR.
    floor_up  = (current_floor == TOP_FLOOR) ? current_floor : current_floor + FLOOR_W'(1);
    floor_dn  = (current_floor == '0) ? current_floor : current_floor - FLOOR_W'(1);
    hot_cur   = onehot(current_floor);
    hot_up    = onehot(floor_up);
    hot_dn    = onehot(floor_dn);
    above_cur = any_above(req, current_floor);
    below_cur = any_below(req, current_floor);
    here_cur  = |(req & hot_cur);
    above_up  = any_above(req, floor_up);
    below_dn  = any_below(req, floor_dn);

    // A hall call against the travel direction is only taken at the end of the sweep.
    turn_up   = (|(active_out_down_levels & hot_up)) & ~above_up;
    stop_up   = (|((active_in_levels | active_out_up_levels) & hot_up)) | turn_up;
    turn_dn   = (|(active_out_up_levels & hot_dn)) & ~below_dn;
    stop_dn   = (|((active_in_levels | active_out_down_levels) & hot_dn)) | turn_dn;

    // Bits already being cleared this cycle are still high at the inputs; mask them.
    reopen_in = active_in_levels & hot_cur & ~inactivate_in_levels;
    reopen_up = served_up ? (active_out_up_levels & hot_cur & ~inactivate_out_up_levels)
                          : '0;
    reopen_dn = served_down ? (active_out_down_levels & hot_cur & ~inactivate_out_down_levels)
                            : '0;
    reopen    = |{reopen_in, reopen_up, reopen_dn};

`ifdef ELEVATOR_ESTOP_EN
    freeze    = estop;
`else
    freeze    = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                      <= S_IDLE;
      current_floor              <= '0;
      direction                  <= DIR_NONE;
      door_open                  <= 1'b0;
      moving                     <= 1'b0;
      travel_cnt                 <= '0;
      door_cnt                   <= '0;
      served_up                  <= 1'b0;
      served_down                <= 1'b0;
      buttons_blocked            <= '0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
    end else if (freeze) begin
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
      moving                     <= 1'b0;
      door_open                  <= (state == S_DOOR_OPEN);
    end else begin
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;

      case (state)
        S_IDLE: begin
          if (here_cur) begin
            state                      <= S_DOOR_OPEN;
            door_open                  <= 1'b1;
            door_cnt                   <= DOOR_LOAD;
            buttons_blocked            <= 5'(current_floor) + 5'd1;
            inactivate_in_levels       <= active_in_levels & hot_cur;
            inactivate_out_up_levels   <= active_out_up_levels & hot_cur;
            inactivate_out_down_levels <= active_out_down_levels & hot_cur;
            served_up                  <= 1'b1;
            served_down                <= 1'b1;
            direction                  <= DIR_NONE;
          end else if (above_cur) begin
            state      <= S_MOVE_UP;
            direction  <= DIR_UP;
            moving     <= 1'b1;
            travel_cnt <= TRAVEL_LOAD;
          end else if (below_cur) begin
            state      <= S_MOVE_DOWN;
            direction  <= DIR_DOWN;
            moving     <= 1'b1;
            travel_cnt <= TRAVEL_LOAD;
          end else begin
            direction <= DIR_NONE;
          end
        end

        S_MOVE_UP: begin
          if (travel_cnt != '0) begin
            travel_cnt <= travel_cnt - TCW'(1);
          end else begin
            current_floor <= floor_up;
            if (stop_up) begin
              state                      <= S_DOOR_OPEN;
              moving                     <= 1'b0;
              door_open                  <= 1'b1;
              door_cnt                   <= DOOR_LOAD;
              buttons_blocked            <= 5'(floor_up) + 5'd1;
              inactivate_in_levels       <= active_in_levels & hot_up;
              inactivate_out_up_levels   <= active_out_up_levels & hot_up;
              inactivate_out_down_levels <= turn_up ? (active_out_down_levels & hot_up) : '0;
              served_up                  <= 1'b1;
              served_down                <= turn_up;
              direction                  <= turn_up ? DIR_DOWN : DIR_UP;
            end else if (above_up) begin
              travel_cnt <= TRAVEL_LOAD;
            end else begin
              state     <= S_IDLE;
              direction <= DIR_NONE;
              moving    <= 1'b0;
            end
          end
        end

        S_MOVE_DOWN: begin
          if (travel_cnt != '0) begin
            travel_cnt <= travel_cnt - TCW'(1);
          end else begin
            current_floor <= floor_dn;
            if (stop_dn) begin
              state                      <= S_DOOR_OPEN;
              moving                     <= 1'b0;
              door_open                  <= 1'b1;
              door_cnt                   <= DOOR_LOAD;
              buttons_blocked            <= 5'(floor_dn) + 5'd1;
              inactivate_in_levels       <= active_in_levels & hot_dn;
              inactivate_out_down_levels <= active_out_down_levels & hot_dn;
              inactivate_out_up_levels   <= turn_dn ? (active_out_up_levels & hot_dn) : '0;
              served_down                <= 1'b1;
              served_up                  <= turn_dn;
              direction                  <= turn_dn ? DIR_UP : DIR_DOWN;
            end else if (below_dn) begin
              travel_cnt <= TRAVEL_LOAD;
            end else begin
              state     <= S_IDLE;
              direction <= DIR_NONE;
              moving    <= 1'b0;
            end
          end
        end

        S_DOOR_OPEN: begin
          if (reopen) begin
            inactivate_in_levels       <= reopen_in;
            inactivate_out_up_levels   <= reopen_up;
            inactivate_out_down_levels <= reopen_dn;
            door_cnt                   <= DOOR_LOAD;
          end else if (door_cnt != '0) begin
            door_cnt <= door_cnt - DCW'(1);
          end else begin
            door_open       <= 1'b0;
            buttons_blocked <= '0;
            if (direction == DIR_UP && above_cur) begin
              state      <= S_MOVE_UP;
              moving     <= 1'b1;
              travel_cnt <= TRAVEL_LOAD;
            end else if (direction == DIR_DOWN && below_cur) begin
              state      <= S_MOVE_DOWN;
              moving     <= 1'b1;
              travel_cnt <= TRAVEL_LOAD;
            end else begin
              state     <= S_IDLE;
              direction <= DIR_NONE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
